// File: rtl/pwm_cfg_ctrl_if.sv
// Frame handshake between the SPI peripheral (master) and the PWM config controller (slave).
interface pwm_cfg_ctrl_if;
  logic        frm_valid;
  logic        frm_ready;
  logic [15:0] frm_data;

  modport master (output frm_valid, output frm_data, input frm_ready);
  modport slave  (input frm_valid, input frm_data, output frm_ready);
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// PWM configuration controller: validates SPI write frames into a shadow bank and
// commits the shadow to the active bank at period_end or after a bounded wait.
module pwm_cfg_ctrl #(
  parameter int unsigned COMMIT_TIMEOUT = 255,
  parameter int unsigned ERR_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  pwm_cfg_ctrl_if.slave      frm,
  input  logic               period_end,
  output logic [15:0]        en_out,
  output logic [15:0]        en_pwm,
  output logic [7:0]         duty,
  output logic               pending,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int unsigned TMR_W    = $clog2(COMMIT_TIMEOUT + 1);
  localparam int unsigned NUM_REGS = 5;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

  state_t                       state;
  logic [15:0]                  frame_q;
  logic [NUM_REGS-1:0][7:0]     shadow_q;
  logic [NUM_REGS-1:0][7:0]     active_q;
  logic [TMR_W-1:0]             timer_q;
  logic                         write_c;
  logic                         commit_c;
  logic                         frame_ok_c;

  assign write_c    = (state == WRITE);
  assign commit_c   = pending && (period_end || (timer_q == TMR_W'(COMMIT_TIMEOUT)));
  assign frame_ok_c = frame_q[15] && (frame_q[14:8] <= 7'h04);

  // Outputs come straight from the active bank registers.
  assign en_out = {active_q[1], active_q[0]};
  assign en_pwm = {active_q[3], active_q[2]};
  assign duty   = active_q[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frm.frm_ready <= 1'b0;
      frame_q       <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending       <= 1'b0;
      timer_q       <= '0;
      err_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          frm.frm_ready <= 1'b1;
          if (frm.frm_valid && frm.frm_ready) begin
            frame_q       <= frm.frm_data;
            frm.frm_ready <= 1'b0;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (frame_ok_c) begin
            state <= WRITE;
          end else begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            frm.frm_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        WRITE: begin
          shadow_q[frame_q[10:8]] <= frame_q[7:0];
          frm.frm_ready           <= 1'b1;
          state                   <= IDLE;
        end
        default: begin
          frm.frm_ready <= 1'b0;
          state         <= IDLE;
        end
      endcase

      // A commit copies the pre-write shadow; a coincident write keeps pending set.
      if (commit_c) active_q <= shadow_q;
      pending <= write_c || (pending && !commit_c);

      // Timer only runs while a pending update waits; further writes never restart it.
      if (!pending || commit_c) begin
        timer_q <= '0;
      end else if (timer_q != TMR_W'(COMMIT_TIMEOUT)) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Bench for pwm_cfg_ctrl: two instances (long and short commit timeout) driven by the same
// stimulus and compared every cycle against a frame-level reference model.
module tb_pwm_cfg_ctrl;

  localparam int unsigned TO_A = 255;
  localparam int unsigned TO_B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        pe = 1'b0;

  pwm_cfg_ctrl_if if_a ();
  pwm_cfg_ctrl_if if_b ();
  assign if_a.frm_valid = valid;
  assign if_a.frm_data  = data;
  assign if_b.frm_valid = valid;
  assign if_b.frm_data  = data;

  logic [15:0] en_out_a, en_pwm_a, en_out_b, en_pwm_b;
  logic [7:0]  duty_a, duty_b;
  logic        pend_a, pend_b;
  logic [3:0]  err_a, err_b;

  pwm_cfg_ctrl #(.COMMIT_TIMEOUT(TO_A), .ERR_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .frm(if_a.slave), .period_end(pe),
    .en_out(en_out_a), .en_pwm(en_pwm_a), .duty(duty_a), .pending(pend_a), .err_cnt(err_a));

  pwm_cfg_ctrl #(.COMMIT_TIMEOUT(TO_B), .ERR_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .frm(if_b.slave), .period_end(pe),
    .en_out(en_out_b), .en_pwm(en_pwm_b), .duty(duty_b), .pending(pend_b), .err_cnt(err_b));

  always #5 clk = ~clk;

  // Reference model: a frame in flight takes one cycle to validate and one more to land.
  typedef struct {
    logic            started;
    logic            inflight;
    int              age;
    logic [15:0]     frame;
    logic [4:0][7:0] shadow;
    logic [4:0][7:0] active;
    logic            pend;
    int unsigned     timer;
    int unsigned     err;
  } m_t;

  m_t ma, mb;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic m_t mreset();
    m_t m;
    m.started = 0; m.inflight = 0; m.age = 0; m.frame = '0;
    m.shadow = '0; m.active = '0; m.pend = 0; m.timer = 0; m.err = 0;
    return m;
  endfunction

  function automatic m_t mstep(m_t m, int unsigned to, logic v, logic [15:0] d, logic p);
    m_t   n = m;
    logic wr = 1'b0;
    logic commit;
    commit = m.pend && (p || (m.timer == to));
    if (m.inflight) begin
      if (m.age == 0) begin
        if (m.frame[15] && (m.frame[14:8] <= 7'd4)) n.age = 1;
        else begin
          n.inflight = 0;
          if (m.err < 15) n.err = m.err + 1;
        end
      end else begin
        wr = 1'b1;
        n.inflight = 0;
      end
    end else if (m.started && v) begin
      n.inflight = 1; n.age = 0; n.frame = d;
    end
    n.started = 1;
    if (commit) n.active = m.shadow;
    if (wr) n.shadow[m.frame[10:8]] = m.frame[7:0];
    n.pend  = wr || (m.pend && !commit);
    n.timer = (commit || !m.pend) ? 0 : ((m.timer < to) ? m.timer + 1 : m.timer);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_models();
    chk("a_ready",  32'(if_a.frm_ready), 32'(ma.started && !ma.inflight));
    chk("a_en_out", 32'(en_out_a), 32'({ma.active[1], ma.active[0]}));
    chk("a_en_pwm", 32'(en_pwm_a), 32'({ma.active[3], ma.active[2]}));
    chk("a_duty",   32'(duty_a),   32'(ma.active[4]));
    chk("a_pend",   32'(pend_a),   32'(ma.pend));
    chk("a_err",    32'(err_a),    ma.err);
    chk("b_ready",  32'(if_b.frm_ready), 32'(mb.started && !mb.inflight));
    chk("b_en_out", 32'(en_out_b), 32'({mb.active[1], mb.active[0]}));
    chk("b_en_pwm", 32'(en_pwm_b), 32'({mb.active[3], mb.active[2]}));
    chk("b_duty",   32'(duty_b),   32'(mb.active[4]));
    chk("b_pend",   32'(pend_b),   32'(mb.pend));
    chk("b_err",    32'(err_b),    mb.err);
  endtask

  // One clock: models step on the same inputs the DUTs sample, then outputs are compared.
  task automatic cycle();
    @(posedge clk);
    ma = mstep(ma, TO_A, valid, data, pe);
    mb = mstep(mb, TO_B, valid, data, pe);
    cyc++;
    #1;
    check_models();
  endtask

  task automatic do_reset();
    valid = 0; pe = 0; data = '0;
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(if_a.frm_ready), 0);
    chk("rst_duty",  32'(duty_a), 0);
    chk("rst_pend",  32'(pend_b), 0);
    rst = 0;
    ma = mreset();
    mb = mreset();
    cycle();
    chk("ready_after_rst", 32'(if_a.frm_ready), 1);
  endtask

  task automatic send_frame(input logic [15:0] f);
    int n = 0;
    while (!if_a.frm_ready && n < 10) begin cycle(); n++; end
    chk("ready_wait", 32'(if_a.frm_ready), 1);
    valid = 1; data = f;
    cycle();
    valid = 0;
    cycle();
    cycle();
  endtask

  task automatic pulse_pe();
    pe = 1; cycle(); pe = 0;
  endtask

  typedef struct {
    logic [15:0] frame;
    logic        exp_pend;
    logic [15:0] exp_en_out;
    logic [15:0] exp_en_pwm;
    logic [7:0]  exp_duty;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int acc[3];
    logic [15:0] fr3[3];
    int c0;
    int n;

    vecs[0] = '{16'h8001, 1'b1, 16'h0001, 16'h0000, 8'h00, 4'd0};
    vecs[1] = '{16'h81A5, 1'b1, 16'hA501, 16'h0000, 8'h00, 4'd0};
    vecs[2] = '{16'h8233, 1'b1, 16'hA501, 16'h0033, 8'h00, 4'd0};
    vecs[3] = '{16'h83C0, 1'b1, 16'hA501, 16'hC033, 8'h00, 4'd0};
    vecs[4] = '{16'h847F, 1'b1, 16'hA501, 16'hC033, 8'h7F, 4'd0};
    vecs[5] = '{16'h0412, 1'b0, 16'hA501, 16'hC033, 8'h7F, 4'd1};
    vecs[6] = '{16'h8512, 1'b0, 16'hA501, 16'hC033, 8'h7F, 4'd2};
    vecs[7] = '{16'hFF00, 1'b0, 16'hA501, 16'hC033, 8'h7F, 4'd3};
    vecs[8] = '{16'h8000, 1'b1, 16'hA500, 16'hC033, 8'h7F, 4'd3};

    ma = mreset();
    mb = mreset();

    // Table-driven register map and rejection checks
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].frame);
      chk("tbl_pend", 32'(pend_a), 32'(vecs[i].exp_pend));
      pulse_pe();
      chk("tbl_en_out", 32'(en_out_a), 32'(vecs[i].exp_en_out));
      chk("tbl_en_pwm", 32'(en_pwm_a), 32'(vecs[i].exp_en_pwm));
      chk("tbl_duty",   32'(duty_a),   32'(vecs[i].exp_duty));
      chk("tbl_err",    32'(err_a),    32'(vecs[i].exp_err));
      chk("tbl_pend_after", 32'(pend_a), 0);
    end

    // Duty held in shadow until period_end
    do_reset();
    send_frame(16'h8455);
    for (int k = 0; k < 10; k++) begin
      chk("p30_duty_hold", 32'(duty_a), 0);
      chk("p30_pend_hold", 32'(pend_a), 1);
      if (k < 9) cycle();
    end
    pulse_pe();
    chk("p30_duty", 32'(duty_a), 32'h55);
    chk("p30_pend", 32'(pend_a), 0);

    // Timeout-forced commit on the short-timeout instance
    do_reset();
    send_frame(16'h8012);
    c0 = cyc;
    send_frame(16'h8134);
    send_frame(16'h82FF);
    n = 0;
    while (cyc < c0 + 8 && n < 20) begin cycle(); n++; end
    chk("p31_pre_en_out", 32'(en_out_b), 0);
    chk("p31_pre_pend",   32'(pend_b), 1);
    cycle();
    chk("p31_en_out", 32'(en_out_b), 32'h3412);
    chk("p31_en_pwm", 32'(en_pwm_b), 32'h00FF);
    chk("p31_pend",   32'(pend_b), 0);
    chk("p31_a_hold", 32'(en_out_a), 0);

    // Rejected frames and error counter saturation
    do_reset();
    send_frame(16'h0400);
    send_frame(16'h8A01);
    chk("p32_err",  32'(err_a), 2);
    chk("p32_pend", 32'(pend_a), 0);
    pulse_pe();
    chk("p32_no_commit", 32'(pend_a), 0);
    send_frame(16'h8201);
    pulse_pe();
    chk("p32_en_out", 32'(en_out_a), 0);
    chk("p32_duty",   32'(duty_a), 0);
    chk("p32_en_pwm", 32'(en_pwm_a), 32'h0001);
    for (int k = 0; k < 20; k++) send_frame(16'h0000);
    chk("p32_err_sat", 32'(err_a), 32'hF);

    // Write landing on the same edge as a commit
    do_reset();
    send_frame(16'h8411);
    valid = 1; data = 16'h8477;
    cycle();
    valid = 0;
    cycle();
    pe = 1; cycle(); pe = 0;
    chk("p33_duty_old", 32'(duty_a), 32'h11);
    chk("p33_pend",     32'(pend_a), 1);
    cycle(); cycle();
    pulse_pe();
    chk("p33_duty_new", 32'(duty_a), 32'h77);
    chk("p33_pend_clr", 32'(pend_a), 0);

    // Back-to-back accepts with frm_valid held high
    do_reset();
    fr3[0] = 16'h8001; fr3[1] = 16'h8102; fr3[2] = 16'h8403;
    valid = 1;
    for (int i = 0; i < 3; i++) begin
      data = fr3[i];
      n = 0;
      while (!if_a.frm_ready && n < 10) begin cycle(); n++; end
      acc[i] = cyc;
      cycle();
      chk("p34_ready_check", 32'(if_a.frm_ready), 0);
      cycle();
      chk("p34_ready_write", 32'(if_a.frm_ready), 0);
      if (i == 2) valid = 0;
      cycle();
    end
    chk("p34_gap01", 32'(acc[1] - acc[0]), 3);
    chk("p34_gap12", 32'(acc[2] - acc[1]), 3);
    pulse_pe();
    chk("p34_en_out", 32'(en_out_a), 32'h0201);
    chk("p34_duty",   32'(duty_a), 32'h03);

    // Reset during the validation cycle drops the frame
    do_reset();
    valid = 1; data = 16'h8499;
    cycle();
    valid = 0;
    rst = 1;
    #1;
    chk("p35_ready_rst", 32'(if_a.frm_ready), 0);
    chk("p35_pend_rst",  32'(pend_a), 0);
    @(posedge clk);
    #1;
    chk("p35_duty_rst", 32'(duty_a), 0);
    chk("p35_en_rst",   32'({en_out_a, en_pwm_a}), 0);
    chk("p35_err_rst",  32'(err_a), 0);
    rst = 0;
    ma = mreset();
    mb = mreset();
    cycle();
    chk("p35_ready_after", 32'(if_a.frm_ready), 1);
    for (int k = 0; k < 4; k++) cycle();
    pulse_pe();
    chk("p35_duty_never", 32'(duty_a), 0);
    chk("p35_pend_after", 32'(pend_a), 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = {1'($urandom_range(0, 3) != 0), 4'd0, 3'($urandom_range(0, 7)), 8'($urandom)};
      if ($urandom_range(0, 15) == 0) data[14:11] = 4'($urandom);
      pe    = ($urandom_range(0, 13) == 0);
      cycle();
    end
    valid = 0; pe = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_ctrl.md
PWM_CFG_CTRL -- requirements
Module: pwm_cfg_ctrl

Interface
REQ-001 SHALL provide parameter: COMMIT_TIMEOUT, 255, cycles a pending shadow update may wait for period_end before a forced commit (range 1..65535).
REQ-002 SHALL provide parameter: ERR_W, 4, width of the saturating error counter.
REQ-003 SHALL have port: clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: frm_valid  input  1  SPI peripheral has a complete 16-bit frame on frm_data.
REQ-006 SHALL have port: frm_ready  output  1  controller can accept a frame.
REQ-007 SHALL have port: frm_data  input  16  frame: [15] R/W (1=write), [14:8] address, [7:0] data.
REQ-008 SHALL have port: period_end  input  1  one-cycle pulse from the PWM core at the last cycle of each PWM period.
REQ-009 SHALL have port: en_out  output  16  committed output-enable bits.
REQ-010 SHALL have port: en_pwm  output  16  committed PWM-mode select bits.
REQ-011 SHALL have port: duty  output  8  committed PWM duty cycle.
REQ-012 SHALL have port: pending  output  1  shadow bank holds writes that have not yet been committed.
REQ-013 SHALL have port: err_cnt  output  ERR_W  count of rejected frames, saturating at all-ones.

Function
REQ-014 SHALL keep a shadow bank with this map: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty.
REQ-015 SHALL drive en_out, en_pwm and duty only from an active bank that changes only on commit.
REQ-016 SHALL implement an FSM with states IDLE, CHECK and WRITE; frm_ready is 1 only in IDLE.
REQ-017 SHALL complete a handshake at the edge where frm_valid=1 and frm_ready=1; that edge captures frm_data and moves the FSM IDLE->CHECK.
REQ-018 SHALL, in CHECK, go to WRITE when R/W=1 and address<=0x04; otherwise it increments err_cnt (saturating) and returns to IDLE.
REQ-019 SHALL, in WRITE, load the addressed shadow byte, set pending=1 and return to IDLE.
REQ-020 SHALL leave frm_data ignored outside the accept edge, so frm_valid held high produces back-to-back accepts at most one per 3 cycles.
REQ-021 SHALL keep a commit timer: cleared when pending=0, incremented each cycle while pending=1, saturating at COMMIT_TIMEOUT.
REQ-022 SHALL commit at any edge where pending=1 and (period_end=1 or timer==COMMIT_TIMEOUT): copy all shadow bytes to the active bank, clear pending and clear the timer.
REQ-023 SHALL make the result visible on the outputs the cycle after the commit edge.
REQ-024 SHALL resolve a WRITE and a commit on the same edge as follows: the commit copies the pre-write shadow, the new byte lands in shadow, pending stays 1 and the timer restarts from 0.
REQ-025 SHALL neither commit nor increment the timer when period_end=1 and pending=0.
REQ-026 SHALL never restart the timer on further writes while pending=1; a timeout-forced commit bounds update latency regardless of write traffic.

Reset
REQ-027 SHALL, while rst=1, immediately force: FSM to IDLE, frm_ready=0, shadow and active banks to 0, en_out=0, en_pwm=0, duty=0, pending=0, timer=0, err_cnt=0.
REQ-028 SHALL drop a frame in CHECK or WRITE when rst asserts, with no shadow update.
REQ-029 SHALL assert frm_ready=1 in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover: write frame 0x8455 then period_end 10 cycles later -> duty stays 0x00 and pending=1 until the period_end edge; duty=0x55 and pending=0 the next cycle.
REQ-031 SHALL cover: frames 0x8012, 0x8134, 0x82FF with no period_end and COMMIT_TIMEOUT=8 -> en_out=0x3412 and en_pwm[7:0]=0xFF committed together exactly 8 cycles after the first pending=1 cycle.
REQ-032 SHALL cover: read frame 0x0400 and write frame 0x8A01 (address 0x0A) -> both rejected, err_cnt=2, shadow unchanged, pending=0; 20 bad frames -> err_cnt=0xF.
REQ-033 SHALL cover: WRITE of 0x8477 coinciding with period_end after an earlier 0x8411 -> duty=0x11 after that edge, pending=1, then duty=0x77 at the next period_end.
REQ-034 SHALL cover: frm_valid held high with 3 frames -> exactly one accept every 3 cycles and frm_ready=0 in CHECK and WRITE.
REQ-035 SHALL cover: rst pulse in the CHECK cycle of frame 0x8499 -> all outputs 0, pending=0, frm_ready=1 after release, duty never 0x99.
